// File: rtl/rc4_ram_pkg.sv
// Shared types and constants for the RC4 S-box RAM phase sequencer.
// Holds the sequencer state enum and the lowest-set-bit helper.
package rc4_ram_pkg;

    localparam int DEF_RAM_WIDTH = 8;

    localparam int DEV_INIT    = 0;
    localparam int DEV_SHUFFLE = 1;
    localparam int DEV_DECRYPT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RUN,
        S_SETTLE,
        S_DONE,
        S_FAULT
    } seq_state_t;

    function automatic int unsigned lowest_set(input logic [31:0] mask);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_client_mux.sv
// Selects the granted client's RAM write port; i_force_off gates the write
// enable so the bus is quiet outside a grant.
module ram_client_mux #(
    parameter int RAM_WIDTH   = 8,
    parameter int NUM_DEVICES = 4,
    parameter int IDX_W       = 2
) (
    input  logic [IDX_W-1:0]                 i_sel,
    input  logic                             i_force_off,
    input  logic [NUM_DEVICES-1:0]           i_we,
    input  logic [NUM_DEVICES*RAM_WIDTH-1:0] i_addr,
    input  logic [NUM_DEVICES*RAM_WIDTH-1:0] i_wdata,
    output logic                             o_we,
    output logic [RAM_WIDTH-1:0]             o_addr,
    output logic [RAM_WIDTH-1:0]             o_wdata
);

    always_comb begin
        o_we    = 1'b0;
        o_addr  = '0;
        o_wdata = '0;
        for (int k = 0; k < NUM_DEVICES; k++) begin
            if (i_sel == IDX_W'(k)) begin
                o_we    = i_we[k] & ~i_force_off;
                o_addr  = i_addr[k*RAM_WIDTH +: RAM_WIDTH];
                o_wdata = i_wdata[k*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

endmodule

// File: rtl/ram_phase_sequencer.sv
// Grants the single-port S-box RAM to enabled clients in ascending order,
// with per-phase watchdog, abort and busy/done/error status.
module ram_phase_sequencer
    import rc4_ram_pkg::*;
#(
    parameter int RAM_WIDTH      = DEF_RAM_WIDTH,
    parameter int NUM_DEVICES    = 4,
    parameter int IDX_W          = $clog2(NUM_DEVICES),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             go,
    input  logic                             abort,
    input  logic [NUM_DEVICES-1:0]           phase_en,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [IDX_W-1:0]                 phase,
    output logic [NUM_DEVICES-1:0]           dev_start,
    input  logic [NUM_DEVICES-1:0]           dev_finished,
    input  logic [NUM_DEVICES-1:0]           dev_we,
    input  logic [NUM_DEVICES*RAM_WIDTH-1:0] dev_addr,
    input  logic [NUM_DEVICES*RAM_WIDTH-1:0] dev_wdata,
    output logic                             ram_we,
    output logic [RAM_WIDTH-1:0]             ram_addr,
    output logic [RAM_WIDTH-1:0]             ram_wdata
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [NUM_DEVICES-1:0] r_mask;
    logic [NUM_DEVICES-1:0] w_mask_next;
    logic [IDX_W-1:0]       r_phase;
    logic [IDX_W-1:0]       w_phase_next;
    logic [WD_W-1:0]        r_wdog;
    logic                   r_error;
    logic [NUM_DEVICES-1:0] r_dev_start;
    logic                   w_fin;
    logic                   w_timeout;
    logic                   w_force_off;
    logic                   w_we;
    logic [RAM_WIDTH-1:0]   w_addr;
    logic [RAM_WIDTH-1:0]   w_wdata;

    assign w_fin     = dev_finished[r_phase];
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog >= WD_LAST);

    always_comb begin
        w_next       = r_state;
        w_mask_next  = r_mask;
        w_phase_next = r_phase;
        unique case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_mask_next = phase_en;
                    w_next      = (|phase_en) ? S_SELECT : S_DONE;
                end
            end
            S_SELECT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_phase_next = IDX_W'(lowest_set(32'(r_mask)));
                    // x & (x-1) drops exactly the bit just granted
                    w_mask_next  = r_mask & (r_mask - NUM_DEVICES'(1));
                    w_next       = S_RUN;
                end
            end
            S_RUN: begin
                if (abort)          w_next = S_IDLE;
                else if (w_fin)     w_next = S_SETTLE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_SETTLE: begin
                if (abort)        w_next = S_IDLE;
                else if (|r_mask) w_next = S_SELECT;
                else              w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_phase     <= '0;
            r_wdog      <= '0;
            r_error     <= 1'b0;
            r_dev_start <= '0;
        end else begin
            r_state <= w_next;
            r_mask  <= w_mask_next;
            r_phase <= w_phase_next;
            if (r_state == S_RUN && w_next == S_RUN) begin
                if (r_wdog != '1) r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (r_state == S_IDLE && go)  r_error <= 1'b0;
            else if (w_next == S_FAULT)   r_error <= 1'b1;
            r_dev_start <= (w_next == S_RUN)
                ? (NUM_DEVICES'(1) << w_phase_next) : '0;
        end
    end

    assign w_force_off = (r_state != S_RUN);

    ram_client_mux #(
        .RAM_WIDTH  (RAM_WIDTH),
        .NUM_DEVICES(NUM_DEVICES),
        .IDX_W      (IDX_W)
    ) u_mux (
        .i_sel      (r_phase),
        .i_force_off(w_force_off),
        .i_we       (dev_we),
        .i_addr     (dev_addr),
        .i_wdata    (dev_wdata),
        .o_we       (w_we),
        .o_addr     (w_addr),
        .o_wdata    (w_wdata)
    );

    // Bus parks at zero while idle so reset leaves a clean RAM port
    assign ram_we    = w_we;
    assign ram_addr  = (r_state == S_IDLE) ? '0 : w_addr;
    assign ram_wdata = (r_state == S_IDLE) ? '0 : w_wdata;

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign error     = r_error;
    assign phase     = r_phase;
    assign dev_start = r_dev_start;

endmodule

// File: tb/tb_ram_phase_sequencer.sv
// Self-checking bench: cycle model of the phase schedule plus directed
// scenario checks on a default instance and a short-timeout instance.
module tb_ram_phase_sequencer;
    import rc4_ram_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  phase_en = 4'd0;
    logic        busy, done, error;
    logic [1:0]  phase;
    logic [3:0]  dev_start;
    logic [3:0]  dev_finished = 4'd0;
    logic [3:0]  dev_we = 4'd0;
    logic [31:0] dev_addr = 32'd0;
    logic [31:0] dev_wdata = 32'd0;
    logic        ram_we;
    logic [7:0]  ram_addr, ram_wdata;

    logic        t_go = 1'b0;
    logic [3:0]  t_en = 4'd0;
    logic        t_busy, t_done, t_error;
    logic [1:0]  t_phase;
    logic [3:0]  t_start;
    logic [3:0]  t_fin = 4'd0;
    logic [3:0]  t_we = 4'hF;
    logic [31:0] t_addr = 32'h44332211;
    logic [31:0] t_wdata = 32'h88776655;
    logic        t_ram_we;
    logic [7:0]  t_ram_addr, t_ram_wdata;

    always #5 clk = ~clk;

    ram_phase_sequencer u_dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .phase_en(phase_en), .busy(busy), .done(done), .error(error),
        .phase(phase), .dev_start(dev_start),
        .dev_finished(dev_finished), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    ram_phase_sequencer #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk(clk), .reset(reset), .go(t_go), .abort(1'b0),
        .phase_en(t_en), .busy(t_busy), .done(t_done), .error(t_error),
        .phase(t_phase), .dev_start(t_start),
        .dev_finished(t_fin), .dev_we(t_we),
        .dev_addr(t_addr), .dev_wdata(t_wdata),
        .ram_we(t_ram_we), .ram_addr(t_ram_addr), .ram_wdata(t_ram_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // ---------------- client engines (stimulus) ----------------
    int fin_after [4];
    int cnt [4];
    int cyc = 0;
    bit force_mode = 1'b0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0;
            fin_after[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (dev_start[k]) cnt[k]++;
                else cnt[k] = 0;
                dev_finished[k] = dev_start[k] && fin_after[k] != 0
                                  && cnt[k] >= fin_after[k];
                if (force_mode) begin
                    dev_we[k] = 1'b1;
                    dev_addr[k*8 +: 8] = 8'h7F;
                    dev_wdata[k*8 +: 8] = 8'hA5;
                end else begin
                    dev_we[k] = dev_start[k] ? (cnt[k] % 4 != 3)
                                             : ((cyc + k) % 2 == 1);
                    dev_addr[k*8 +: 8] = 8'(cyc * 3 + k * 37);
                    dev_wdata[k*8 +: 8] = 8'(cyc ^ (k << 4));
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    localparam int M_IDLE  = 0;
    localparam int M_PICK  = 1;
    localparam int M_GRANT = 2;
    localparam int M_GAP   = 3;
    localparam int M_END   = 4;
    localparam int M_TRIP  = 5;
    localparam int M_TO    = 4096;

    int m_stage = M_IDLE;
    int m_rem = 0;
    int m_phase = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    always @(posedge clk) begin
        int low;
        low = 0;
        for (int i = 3; i >= 0; i--)
            if (((m_rem >> i) & 1) != 0) low = i;
        if (reset) begin
            m_stage <= M_IDLE;
            m_rem   <= 0;
            m_phase <= 0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
        end else begin
            case (m_stage)
                M_IDLE: if (go) begin
                    m_err   <= 1'b0;
                    m_rem   <= int'(phase_en);
                    m_stage <= (phase_en != 0) ? M_PICK : M_END;
                end
                M_PICK: if (abort) m_stage <= M_IDLE;
                else begin
                    m_phase <= low;
                    m_rem   <= m_rem & ~(1 << low);
                    m_cnt   <= 0;
                    m_stage <= M_GRANT;
                end
                M_GRANT: if (abort) m_stage <= M_IDLE;
                else if (dev_finished[m_phase]) m_stage <= M_GAP;
                else if (m_cnt + 1 >= M_TO) begin
                    m_stage <= M_TRIP;
                    m_err   <= 1'b1;
                end else m_cnt <= m_cnt + 1;
                M_GAP: if (abort) m_stage <= M_IDLE;
                else m_stage <= (m_rem != 0) ? M_PICK : M_END;
                default: m_stage <= M_IDLE;
            endcase
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        bit g;
        if (chk_en) begin
            g = (m_stage == M_GRANT);
            check("busy", 32'(busy), 32'(m_stage != M_IDLE));
            check("done", 32'(done), 32'(m_stage == M_END));
            check("error", 32'(error), 32'(m_err));
            check("phase", 32'(phase), 32'(m_phase));
            check("dev_start", 32'(dev_start), g ? (32'd1 << m_phase) : 32'd0);
            check("ram_we", 32'(ram_we), g ? 32'(dev_we[m_phase]) : 32'd0);
            check("ram_addr", 32'(ram_addr), (m_stage != M_IDLE)
                  ? 32'(dev_addr[m_phase*8 +: 8]) : 32'd0);
            check("ram_wdata", 32'(ram_wdata), (m_stage != M_IDLE)
                  ? 32'(dev_wdata[m_phase*8 +: 8]) : 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    int t_nb, t_nd, t_gap, t_gapwe, t_ok;
    int t_c [4];
    logic [3:0] t_seen;
    logic t_lastdone;

    task automatic go_pulse(input logic [3:0] m);
        @(posedge clk); #1;
        phase_en = m;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic collect(input int budget);
        t_nb = 0; t_nd = 0; t_gap = 0; t_gapwe = 0; t_ok = 0;
        t_seen = 4'd0; t_lastdone = 1'b0;
        for (int k = 0; k < 4; k++) t_c[k] = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                t_ok = 1;
                break;
            end
            t_nb++;
            for (int k = 0; k < 4; k++)
                if (dev_start == 4'(1 << k)) t_c[k]++;
            if (done) t_nd++;
            if (dev_start == 4'd0) begin
                t_gap++;
                if (ram_we) t_gapwe++;
            end else begin
                t_seen = t_seen | 4'(1 << phase);
            end
            t_lastdone = done;
        end
        check("seq_terminates", 32'(t_ok), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int s, f, nd, found;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(dev_start), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_to_err", 32'(t_error), 32'd0);

        // full sequence 0011
        fin_after[0] = 256;
        fin_after[1] = 768;
        go_pulse(4'b0011);
        collect(5000);
        check("full_dev0_cycles", 32'(t_c[0]), 32'd256);
        check("full_dev1_cycles", 32'(t_c[1]), 32'd768);
        check("full_done_count", 32'(t_nd), 32'd1);
        check("full_idle_gaps", 32'(t_gap), 32'd5);
        check("full_gap_we", 32'(t_gapwe), 32'd0);
        check("full_busy_cycles", 32'(t_nb), 32'd1029);
        check("full_done_last", 32'(t_lastdone), 32'd1);
        check("full_done_after", 32'(done), 32'd0);

        // sparse 1010, with an ignored go during the run
        fin_after[0] = 0;
        fin_after[1] = 5;
        fin_after[3] = 7;
        go_pulse(4'b1010);
        go_pulse(4'b0001);
        collect(200);
        check("sparse_dev0", 32'(t_c[0]), 32'd0);
        check("sparse_dev2", 32'(t_c[2]), 32'd0);
        check("sparse_dev3", 32'(t_c[3]), 32'd7);
        check("sparse_seen", 32'(t_seen), 32'b1010);
        check("sparse_done", 32'(t_nd), 32'd1);

        // empty mask
        go_pulse(4'b0000);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_start", 32'(dev_start), 32'd0);
        @(negedge clk);
        check("empty_idle", 32'(busy), 32'd0);
        check("empty_done_drop", 32'(done), 32'd0);

        // full-length watchdog on the default instance
        fin_after[2] = 0;
        go_pulse(4'b0100);
        collect(5000);
        check("wd_busy_cycles", 32'(t_nb), 32'd4098);
        check("wd_dev2_cycles", 32'(t_c[2]), 32'd4096);
        check("wd_no_done", 32'(t_nd), 32'd0);
        check("wd_error", 32'(error), 32'd1);
        fin_after[0] = 3;
        go_pulse(4'b0001);
        @(negedge clk);
        check("wd_err_cleared", 32'(error), 32'd0);
        collect(100);
        check("wd_next_done", 32'(t_nd), 32'd1);
        check("wd_next_dev0", 32'(t_c[0]), 32'd3);

        // short watchdog instance
        @(posedge clk); #1;
        t_en = 4'b0001;
        t_go = 1'b1;
        @(posedge clk); #1;
        t_go = 1'b0;
        s = -1; f = -1; nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s < 0 && t_start != 0) begin
                s = i;
                check("to_ram_we", 32'(t_ram_we), 32'd1);
                check("to_ram_addr", 32'(t_ram_addr), 32'h11);
            end
            if (f < 0 && t_error) f = i;
            if (t_done) nd++;
            if (f >= 0 && !t_busy) break;
        end
        check("to_fault_delay", 32'(f - s), 32'd16);
        check("to_no_done", 32'(nd), 32'd0);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(t_error), 32'd1);
        check("to_idle", 32'(t_busy), 32'd0);
        @(posedge clk); #1;
        t_en = 4'b0000;
        t_go = 1'b1;
        @(posedge clk); #1;
        t_go = 1'b0;
        @(negedge clk);
        check("to_err_clear", 32'(t_error), 32'd0);
        check("to_done", 32'(t_done), 32'd1);

        // abort mid-run on device 1
        fin_after[0] = 4;
        fin_after[1] = 0;
        go_pulse(4'b0011);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dev_start == 4'b0010) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_dev1", 32'(found), 32'd1);
        repeat (49) @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_start", 32'(dev_start), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        fin_after[0] = 2;
        fin_after[1] = 2;
        go_pulse(4'b0011);
        @(negedge clk);
        @(negedge clk);
        check("restart_start", 32'(dev_start), 32'b0001);
        check("restart_phase", 32'(phase), 32'd0);
        collect(100);

        // reset mid-run while the client drives the bus
        fin_after[0] = 0;
        force_mode = 1'b1;
        go_pulse(4'b0001);
        @(negedge clk);
        @(negedge clk);
        check("frc_we", 32'(ram_we), 32'd1);
        check("frc_addr", 32'(ram_addr), 32'h7F);
        check("frc_wdata", 32'(ram_wdata), 32'hA5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rrun_busy", 32'(busy), 32'd0);
        check("rrun_we", 32'(ram_we), 32'd0);
        check("rrun_addr", 32'(ram_addr), 32'd0);
        check("rrun_wdata", 32'(ram_wdata), 32'd0);
        check("rrun_start", 32'(dev_start), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        go = 1'b1;
        phase_en = 4'b0001;
        @(posedge clk); #1;
        reset = 1'b0;
        go = 1'b0;
        @(negedge clk);
        check("gorst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("gorst_busy2", 32'(busy), 32'd0);
        force_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
